disp_beep_ctrl: RTL and testbench

- Parametrised display and beeper controller for the board's 7-segment bank and buzzer.
- Takes NUM_DIGITS BCD digits and a per-digit flicker mask, and drives a decoded 7-segment pattern for digit 0 plus raw BCD codes for the other digits, all registered. Flickering digits blank at a derived blink rate.
- Contains a timed beep sequencer with three patterns (continuous, slow, fast), programmable duration, retrigger and cancel.
- Sits between the application FSM and the board output pins, clocked by the 1 kHz base clock.

---
 rtl/disp_beep_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_disp_beep_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_beep_ctrl.sv
// disp_beep_ctrl
// Display and beeper controller for the 7-segment bank and the buzzer.
//
// Ports:
//   clk_1khz       1 kHz system clock; all state updates on the rising edge
//   rst            synchronous active-high reset
//   digit_data     NUM_DIGITS packed BCD digits, digit i in bits [4i+3:4i]
//   flicker_mask   bit i set makes digit i blink at the 4 Hz blink rate
//   display_en     0 blanks every digit
//   beep_start     one-cycle request; samples beep_mode and beep_len
//   beep_mode      0 cancel, 1 continuous, 2 slow (2 Hz), 3 fast (4 Hz)
//   beep_len       beep duration in cycles, 0 = until cancelled
//   LED7S_out      decoded gfedcba segments for digit 0 (registered)
//   LED7S_bcd_out  raw BCD codes for digits 1..NUM_DIGITS-1 (registered)
//   beep           buzzer drive (registered)
//   beep_busy      high while a beep sequence is running (registered)

module disp_beep_ctrl #(
  parameter int         NUM_DIGITS = 6,
  parameter int         BLINK_HALF = 125,
  parameter int         SLOW_HALF  = 250,
  parameter int         LEN_W      = 12,
  parameter logic [3:0] BLANK_CODE = 4'hf
) (
  input  logic                          clk_1khz,
  input  logic                          rst,
  input  logic [4*NUM_DIGITS-1:0]       digit_data,
  input  logic [NUM_DIGITS-1:0]         flicker_mask,
  input  logic                          display_en,
  input  logic                          beep_start,
  input  logic [1:0]                    beep_mode,
  input  logic [LEN_W-1:0]              beep_len,
  output logic [6:0]                    LED7S_out,
  output logic [4*(NUM_DIGITS-1)-1:0]   LED7S_bcd_out,
  output logic                          beep,
  output logic                          beep_busy
);

  localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int PAT_MAX = (SLOW_HALF > BLINK_HALF) ? SLOW_HALF : BLINK_HALF;
  localparam int PAT_W   = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;

  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
  localparam logic [PAT_W-1:0]   SLOW_LAST  = PAT_W'(SLOW_HALF - 1);
  localparam logic [PAT_W-1:0]   FAST_LAST  = PAT_W'(BLINK_HALF - 1);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } beepState_t;

  // Free-running blink divider
  logic [BLINK_W-1:0] r_blinkCnt;
  logic               r_blinkPhase;

  // Display next-state
  logic [NUM_DIGITS-1:0]             w_visible;
  logic [6:0]                        w_ledNext;
  logic [4*(NUM_DIGITS-1)-1:0]       w_bcdNext;

  // Beep sequencer state
  beepState_t         r_state;
  logic [1:0]         r_mode;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_durCnt;
  logic [PAT_W-1:0]   r_patCnt;
  logic               r_gate;
  logic               r_tone;

  // Beep sequencer combinational helpers
  logic               w_startRun;
  logic               w_cancel;
  logic [PAT_W-1:0]   w_patLast;
  logic               w_patWrap;
  logic               w_gateNext;
  logic               w_toneNext;
  logic               w_durDone;

  function automatic logic [6:0] decodeBcd(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111100;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1100111;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

  // The blink divider runs continuously so the flicker rate never depends
  // on what the beeper is doing; the phase flips each time the count wraps.
  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      r_blinkCnt   <= '0;
      r_blinkPhase <= 1'b1;
    end else if (r_blinkCnt == BLINK_LAST) begin
      r_blinkCnt   <= '0;
      r_blinkPhase <= ~r_blinkPhase;
    end else begin
      r_blinkCnt   <= r_blinkCnt + BLINK_W'(1);
    end
  end

  // Work out which digits are lit this cycle and what each output digit
  // should show. Only digit 0 is decoded; the rest leave the chip as BCD.
  always_comb begin
    w_visible = '0;
    w_bcdNext = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_visible[i] = display_en & (~flicker_mask[i] | r_blinkPhase);
    end
    w_ledNext = w_visible[0] ? decodeBcd(digit_data[3:0]) : 7'b0000000;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      w_bcdNext[4*(i-1) +: 4] = w_visible[i] ? digit_data[4*i +: 4] : BLANK_CODE;
    end
  end

  // Register the display outputs so the pins see a clean one-cycle-late copy.
  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      LED7S_out     <= 7'b0000000;
      LED7S_bcd_out <= {(NUM_DIGITS-1){BLANK_CODE}};
    end else begin
      LED7S_out     <= w_ledNext;
      LED7S_bcd_out <= w_bcdNext;
    end
  end

  // Decode the request and precompute the gate/tone values for a RUN cycle
  // with no new request, so the registered beep can use next-cycle values.
  always_comb begin
    w_startRun = beep_start && (beep_mode != 2'd0);
    w_cancel   = beep_start && (beep_mode == 2'd0);
    w_patLast  = (r_mode == 2'd2) ? SLOW_LAST : FAST_LAST;
    w_patWrap  = (r_patCnt == w_patLast);
    w_toneNext = ~r_tone;
    if (r_mode == 2'd1) begin
      w_gateNext = 1'b1;
    end else begin
      w_gateNext = w_patWrap ? ~r_gate : r_gate;
    end
    w_durDone  = (r_len != '0) && (r_durCnt == LEN_W'(1));
  end

  // Beep sequencer. A start request (any non-zero mode) loads everything,
  // whether idle or already running, so a retrigger restarts the pattern
  // phase and the tone at the high half. beep is produced from the values
  // being loaded so the first high appears one cycle after the request.
  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_mode    <= 2'd0;
      r_len     <= '0;
      r_durCnt  <= '0;
      r_patCnt  <= '0;
      r_gate    <= 1'b0;
      r_tone    <= 1'b0;
      beep      <= 1'b0;
      beep_busy <= 1'b0;
    end else if (w_startRun) begin
      r_state   <= ST_RUN;
      r_mode    <= beep_mode;
      r_len     <= beep_len;
      r_durCnt  <= beep_len;
      r_patCnt  <= '0;
      r_gate    <= 1'b1;
      r_tone    <= 1'b1;
      beep      <= 1'b1;
      beep_busy <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          beep      <= 1'b0;
          beep_busy <= 1'b0;
        end
        ST_RUN: begin
          if (w_cancel || w_durDone) begin
            r_state   <= ST_IDLE;
            r_tone    <= 1'b0;
            beep      <= 1'b0;
            beep_busy <= 1'b0;
          end else begin
            if (r_len != '0) begin
              r_durCnt <= r_durCnt - LEN_W'(1);
            end
            if ((r_mode == 2'd1) || w_patWrap) begin
              r_patCnt <= '0;
            end else begin
              r_patCnt <= r_patCnt + PAT_W'(1);
            end
            r_gate    <= w_gateNext;
            r_tone    <= w_toneNext;
            beep      <= w_gateNext & w_toneNext;
            beep_busy <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          beep      <= 1'b0;
          beep_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disp_beep_ctrl.sv
// tb_disp_beep_ctrl
// Directed bench for disp_beep_ctrl: display decode/blanking/flicker and the
// beep sequencer (length, patterns, cancel, retrigger, reset).

module tb_disp_beep_ctrl;

  localparam int NUM_DIGITS = 6;
  localparam int LEN_W      = 12;
  localparam int BCD_W      = 4*(NUM_DIGITS-1);

  localparam logic [6:0]       SEG_ONE   = 7'b0000110;
  localparam logic [BCD_W-1:0] BCD_STEADY = 20'h65432;
  localparam logic [BCD_W-1:0] BCD_BLANK  = 20'hFFFFF;

  logic                    clk_1khz;
  logic                    rst;
  logic [4*NUM_DIGITS-1:0] digit_data;
  logic [NUM_DIGITS-1:0]   flicker_mask;
  logic                    display_en;
  logic                    beep_start;
  logic [1:0]              beep_mode;
  logic [LEN_W-1:0]        beep_len;
  logic [6:0]              LED7S_out;
  logic [BCD_W-1:0]        LED7S_bcd_out;
  logic                    beep;
  logic                    beep_busy;

  int total;
  int bad;

  disp_beep_ctrl #(
    .NUM_DIGITS (NUM_DIGITS),
    .BLINK_HALF (125),
    .SLOW_HALF  (250),
    .LEN_W      (LEN_W),
    .BLANK_CODE (4'hf)
  ) dut (
    .clk_1khz      (clk_1khz),
    .rst           (rst),
    .digit_data    (digit_data),
    .flicker_mask  (flicker_mask),
    .display_en    (display_en),
    .beep_start    (beep_start),
    .beep_mode     (beep_mode),
    .beep_len      (beep_len),
    .LED7S_out     (LED7S_out),
    .LED7S_bcd_out (LED7S_bcd_out),
    .beep          (beep),
    .beep_busy     (beep_busy)
  );

  // Free-running clock
  initial begin
    clk_1khz = 1'b0;
    forever #5 clk_1khz = ~clk_1khz;
  end

  // Let n rising edges pass, then settle 1 time unit past the last one so
  // outputs are sampled and inputs changed well away from the edge.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk_1khz);
    #1;
  endtask

  // Compare all four observable outputs against hand-computed values.
  task automatic checkOutput(input string tag, input logic [6:0] expLed,
                             input logic [BCD_W-1:0] expBcd,
                             input logic expBeep, input logic expBusy);
    total++;
    assert (LED7S_out === expLed) else begin
      bad++;
      $error("[TB] FAIL %s LED7S_out got=%b want=%b", tag, LED7S_out, expLed);
    end
    total++;
    assert (LED7S_bcd_out === expBcd) else begin
      bad++;
      $error("[TB] FAIL %s LED7S_bcd_out got=%h want=%h", tag, LED7S_bcd_out, expBcd);
    end
    total++;
    assert (beep === expBeep) else begin
      bad++;
      $error("[TB] FAIL %s beep got=%b want=%b", tag, beep, expBeep);
    end
    total++;
    assert (beep_busy === expBusy) else begin
      bad++;
      $error("[TB] FAIL %s beep_busy got=%b want=%b", tag, beep_busy, expBusy);
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    digit_data   = '0;
    flicker_mask = '0;
    display_en   = 1'b0;
    beep_start   = 1'b0;
    beep_mode    = 2'd0;
    beep_len     = '0;

    // Reset state; the last reset edge is cycle 0 of the blink divider
    applyStimulus(3);
    checkOutput("reset", 7'b0000000, BCD_BLANK, 1'b0, 1'b0);

    // Plain display, digit0=1
    rst        = 1'b0;
    digit_data = 24'h654321;
    display_en = 1'b1;
    applyStimulus(1);
    checkOutput("disp_basic", SEG_ONE, BCD_STEADY, 1'b0, 1'b0);

    // Global blank
    display_en = 1'b0;
    applyStimulus(1);
    checkOutput("disp_off", 7'b0000000, BCD_BLANK, 1'b0, 1'b0);

    // Decode 8, hex codes pass unchanged on raw digits
    display_en = 1'b1;
    digit_data = 24'h0987A8;
    applyStimulus(1);
    checkOutput("disp_eight", 7'b1111111, 20'h0987A, 1'b0, 1'b0);

    // Non-BCD code on digit 0 decodes to dark
    digit_data = 24'h00000C;
    applyStimulus(1);
    checkOutput("disp_hexC", 7'b0000000, 20'h00000, 1'b0, 1'b0);

    // Flicker digits 0 and 3; edge 5 still in visible phase
    digit_data   = 24'h654321;
    flicker_mask = 6'b001001;
    applyStimulus(1);
    checkOutput("flick_e5", SEG_ONE, BCD_STEADY, 1'b0, 1'b0);
    applyStimulus(120);
    checkOutput("flick_e125", SEG_ONE, BCD_STEADY, 1'b0, 1'b0);
    applyStimulus(1);
    checkOutput("flick_e126", 7'b0000000, 20'h65F32, 1'b0, 1'b0);
    applyStimulus(124);
    checkOutput("flick_e250", 7'b0000000, 20'h65F32, 1'b0, 1'b0);
    applyStimulus(1);
    checkOutput("flick_e251", SEG_ONE, BCD_STEADY, 1'b0, 1'b0);
    flicker_mask = '0;

    // Continuous beep, 10 cycles: beep alternates 1,0,... while busy
    beep_start = 1'b1;
    beep_mode  = 2'd1;
    beep_len   = 12'd10;
    applyStimulus(1);
    beep_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("cont_k%0d", k), SEG_ONE, BCD_STEADY,
                  ((k % 2) == 0) ? 1'b1 : 1'b0, 1'b1);
      applyStimulus(1);
    end
    checkOutput("cont_end", SEG_ONE, BCD_STEADY, 1'b0, 1'b0);
    applyStimulus(1);
    checkOutput("cont_after", SEG_ONE, BCD_STEADY, 1'b0, 1'b0);

    // Length 1 boundary: busy for exactly one cycle
    beep_start = 1'b1;
    beep_mode  = 2'd1;
    beep_len   = 12'd1;
    applyStimulus(1);
    beep_start = 1'b0;
    checkOutput("len1_k0", SEG_ONE, BCD_STEADY, 1'b1, 1'b1);
    applyStimulus(1);
    checkOutput("len1_k1", SEG_ONE, BCD_STEADY, 1'b0, 1'b0);

    // Fast pattern, endless, then cancel on an edge that would otherwise beep
    beep_start = 1'b1;
    beep_mode  = 2'd3;
    beep_len   = 12'd0;
    applyStimulus(1);
    beep_start = 1'b0;
    checkOutput("fast_k0", SEG_ONE, BCD_STEADY, 1'b1, 1'b1);
    applyStimulus(1);
    checkOutput("fast_k1", SEG_ONE, BCD_STEADY, 1'b0, 1'b1);
    applyStimulus(123);
    checkOutput("fast_k124", SEG_ONE, BCD_STEADY, 1'b1, 1'b1);
    applyStimulus(2);
    checkOutput("fast_k126", SEG_ONE, BCD_STEADY, 1'b0, 1'b1);
    applyStimulus(124);
    checkOutput("fast_k250", SEG_ONE, BCD_STEADY, 1'b1, 1'b1);
    applyStimulus(49);
    checkOutput("fast_k299", SEG_ONE, BCD_STEADY, 1'b0, 1'b1);
    beep_start = 1'b1;
    beep_mode  = 2'd0;
    applyStimulus(1);
    beep_start = 1'b0;
    checkOutput("cancel", SEG_ONE, BCD_STEADY, 1'b0, 1'b0);
    applyStimulus(1);
    checkOutput("cancel_after", SEG_ONE, BCD_STEADY, 1'b0, 1'b0);

    // Cancel while idle does nothing
    beep_start = 1'b1;
    beep_mode  = 2'd0;
    applyStimulus(1);
    beep_start = 1'b0;
    checkOutput("idle_cancel", SEG_ONE, BCD_STEADY, 1'b0, 1'b0);

    // Slow pattern, then retrigger into continuous during the silent half
    beep_start = 1'b1;
    beep_mode  = 2'd2;
    beep_len   = 12'd1000;
    applyStimulus(1);
    beep_start = 1'b0;
    checkOutput("slow_k0", SEG_ONE, BCD_STEADY, 1'b1, 1'b1);
    applyStimulus(248);
    checkOutput("slow_k248", SEG_ONE, BCD_STEADY, 1'b1, 1'b1);
    applyStimulus(2);
    checkOutput("slow_k250", SEG_ONE, BCD_STEADY, 1'b0, 1'b1);
    beep_start = 1'b1;
    beep_mode  = 2'd1;
    beep_len   = 12'd5;
    applyStimulus(1);
    beep_start = 1'b0;
    checkOutput("retrig_r0", SEG_ONE, BCD_STEADY, 1'b1, 1'b1);
    applyStimulus(1);
    checkOutput("retrig_r1", SEG_ONE, BCD_STEADY, 1'b0, 1'b1);
    applyStimulus(3);
    checkOutput("retrig_r4", SEG_ONE, BCD_STEADY, 1'b1, 1'b1);
    applyStimulus(1);
    checkOutput("retrig_r5", SEG_ONE, BCD_STEADY, 1'b0, 1'b0);

    // Reset mid-beep, then reset together with a start request
    beep_start = 1'b1;
    beep_mode  = 2'd1;
    beep_len   = 12'd0;
    applyStimulus(1);
    beep_start = 1'b0;
    checkOutput("rstbeep_k0", SEG_ONE, BCD_STEADY, 1'b1, 1'b1);
    applyStimulus(2);
    checkOutput("rstbeep_k2", SEG_ONE, BCD_STEADY, 1'b1, 1'b1);
    rst = 1'b1;
    applyStimulus(1);
    checkOutput("rst_mid", 7'b0000000, BCD_BLANK, 1'b0, 1'b0);
    beep_start = 1'b1;
    beep_mode  = 2'd1;
    beep_len   = 12'd5;
    applyStimulus(1);
    checkOutput("rst_start", 7'b0000000, BCD_BLANK, 1'b0, 1'b0);
    rst        = 1'b0;
    beep_start = 1'b0;
    applyStimulus(1);
    checkOutput("rst_release", SEG_ONE, BCD_STEADY, 1'b0, 1'b0);
    applyStimulus(1);
    checkOutput("rst_quiet", SEG_ONE, BCD_STEADY, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
